// File: rtl/hazard_control_unit.sv
// hazard_control_unit
//   Resolves the hazards that operand forwarding cannot. It drives the pipeline-register
//   write enables, the flush/bubble controls and a freeze for multi-cycle data-memory
//   accesses:
//     - load-use hazards detected in ID (one bubble cycle),
//     - taken-branch flushes resolved in EX,
//     - data-memory waits in MEM, abandoned after MEM_TIMEOUT cycles.
//   All outputs are combinational from the inputs and the current state.
//
// Parameters
//   MEM_TIMEOUT  maximum cycles spent waiting on data memory (2..255)
//   CNT_W        width of the optional performance counters
//
// Ports
//   clk_i, reset_i                    clock, synchronous active-high reset
//   id_rs1_i/id_rs2_i                 source registers of the ID instruction
//   id_uses_rs1_i/id_uses_rs2_i       the ID instruction really reads rs1/rs2
//   id_ex_rd_i, id_ex_memread_i       destination and load flag of the EX instruction
//   branch_taken_i                    branch/jump resolved taken in EX
//   mem_req_i, mem_ready_i            MEM-stage access request / completion
//   pc_write_o, if_id_write_o         PC and IF/ID write enables
//   if_id_flush_o, id_ex_flush_o      load a NOP into IF/ID, ID/EX
//   id_ex_bubble_o                    zero the controls entering ID/EX
//   pipe_freeze_o                     hold PC, IF/ID, ID/EX and EX/MEM
//   mem_wb_bubble_o                   insert a NOP into MEM/WB
//   mem_timeout_o                     one-cycle pulse when a memory wait is abandoned
//
// Optional feature (macro HAZARD_PERF_EN)
//   stall_cycles_o, flush_count_o, timeout_count_o: wrapping CNT_W-bit event counters.

module hazard_control_unit #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_uses_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic [4:0]       id_ex_rd_i,
    input  logic             id_ex_memread_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic             id_ex_flush_o,
    output logic             pipe_freeze_o,
    output logic             mem_wb_bubble_o,
`ifdef HAZARD_PERF_EN
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_count_o,
    output logic [CNT_W-1:0] timeout_count_o,
`endif
    output logic             mem_timeout_o
);

    if (MEM_TIMEOUT < 2 || MEM_TIMEOUT > 255 || CNT_W < 1) begin : g_param_check
        $error("hazard_control_unit: MEM_TIMEOUT must be 2..255 and CNT_W at least 1");
    end

    typedef enum logic [0:0] {StRun, StMemWait} state_e;

    // Last wait_cnt value before the access is abandoned.
    localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;

    logic lu;
    logic fz;
    logic timeout;

    // Load-use: x0 never stalls because it is never really written.
    always_comb begin
        lu = id_ex_memread_i && (id_ex_rd_i != 5'd0) &&
             ((id_uses_rs1_i && (id_rs1_i == id_ex_rd_i)) ||
              (id_uses_rs2_i && (id_rs2_i == id_ex_rd_i)));
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StRun;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state logic. mem_req_i is assumed held while waiting, so it is not looked at.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            StRun: begin
                if (mem_req_i && !mem_ready_i) begin
                    state_d    = StMemWait;
                    wait_cnt_d = 8'd1;
                end
            end
            StMemWait: begin
                if (mem_ready_i || (wait_cnt_q == WaitLast)) begin
                    state_d    = StRun;
                    wait_cnt_d = 8'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d    = StRun;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    // Freeze / timeout decode from the current state.
    always_comb begin
        fz      = 1'b0;
        timeout = 1'b0;
        unique case (state_q)
            StRun:     fz = mem_req_i && !mem_ready_i;
            StMemWait: begin
                fz      = !mem_ready_i && (wait_cnt_q != WaitLast);
                timeout = !mem_ready_i && (wait_cnt_q == WaitLast);
            end
            default:   fz = 1'b0;
        endcase
    end

    // Output logic, priority: reset > freeze > taken branch > load-use > normal.
    // While frozen, EX and ID are held, so a pending branch or load-use is simply
    // re-evaluated in the release cycle.
    always_comb begin
        pc_write_o      = 1'b1;
        if_id_write_o   = 1'b1;
        if_id_flush_o   = 1'b0;
        id_ex_bubble_o  = 1'b0;
        id_ex_flush_o   = 1'b0;
        pipe_freeze_o   = 1'b0;
        mem_wb_bubble_o = 1'b0;
        mem_timeout_o   = 1'b0;
        if (reset_i) begin
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else begin
            mem_timeout_o = timeout;
            if (fz) begin
                pipe_freeze_o   = 1'b1;
                mem_wb_bubble_o = 1'b1;
                pc_write_o      = 1'b0;
                if_id_write_o   = 1'b0;
            end else if (branch_taken_i) begin
                // The ID instruction is squashed, so a concurrent load-use is moot.
                if_id_flush_o = 1'b1;
                id_ex_flush_o = 1'b1;
            end else if (lu) begin
                pc_write_o     = 1'b0;
                if_id_write_o  = 1'b0;
                id_ex_bubble_o = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;
    logic [CNT_W-1:0] timeout_count_q, timeout_count_d;

    always_comb begin
        stall_cycles_d  = stall_cycles_q;
        flush_count_d   = flush_count_q;
        timeout_count_d = timeout_count_q;
        if (fz || lu) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
        if (!fz && branch_taken_i) begin
            flush_count_d = flush_count_q + 1'b1;
        end
        if (timeout) begin
            timeout_count_d = timeout_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_cycles_q  <= '0;
            flush_count_q   <= '0;
            timeout_count_q <= '0;
        end else begin
            stall_cycles_q  <= stall_cycles_d;
            flush_count_q   <= flush_count_d;
            timeout_count_q <= timeout_count_d;
        end
    end

    assign stall_cycles_o  = stall_cycles_q;
    assign flush_count_o   = flush_count_q;
    assign timeout_count_o = timeout_count_q;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit (MEM_TIMEOUT=4). A driver applies directed
// and random stimulus and pushes the expected response into a queue; a monitor pops and
// compares on the falling edge.

module tb_hazard_control_unit;

    localparam int unsigned T = 4;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_ex_rd = '0;
    logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, id_ex_memread = 1'b0;
    logic       branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
    logic       pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_flush;
    logic       pipe_freeze, mem_wb_bubble, mem_timeout;
`ifdef HAZARD_PERF_EN
    logic [W-1:0] stall_cycles, flush_count, timeout_count;
`endif

    hazard_control_unit #(
        .MEM_TIMEOUT(T),
        .CNT_W      (W)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .id_rs1_i       (id_rs1),
        .id_rs2_i       (id_rs2),
        .id_uses_rs1_i  (id_uses_rs1),
        .id_uses_rs2_i  (id_uses_rs2),
        .id_ex_rd_i     (id_ex_rd),
        .id_ex_memread_i(id_ex_memread),
        .branch_taken_i (branch_taken),
        .mem_req_i      (mem_req),
        .mem_ready_i    (mem_ready),
        .pc_write_o     (pc_write),
        .if_id_write_o  (if_id_write),
        .if_id_flush_o  (if_id_flush),
        .id_ex_bubble_o (id_ex_bubble),
        .id_ex_flush_o  (id_ex_flush),
        .pipe_freeze_o  (pipe_freeze),
        .mem_wb_bubble_o(mem_wb_bubble),
`ifdef HAZARD_PERF_EN
        .stall_cycles_o (stall_cycles),
        .flush_count_o  (flush_count),
        .timeout_count_o(timeout_count),
`endif
        .mem_timeout_o  (mem_timeout)
    );

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       memread;
        logic       br;
        logic       req;
        logic       ready;
    } stim_t;

    // Output bit order: pc_write, if_id_write, if_id_flush, id_ex_bubble,
    // id_ex_flush, pipe_freeze, mem_wb_bubble, mem_timeout.
    typedef struct packed {
        logic [7:0] outs;
        logic [W-1:0] stall;
        logic [W-1:0] flush;
        logic [W-1:0] tmo;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: whether a memory access is outstanding and for how many cycles.
    bit          m_wait = 1'b0;
    int unsigned m_cnt = 0;
    logic [W-1:0] m_stall = '0, m_flush = '0, m_tmo = '0;

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        exp_t e;
        bit   lu, fz, tmo, last;
        @(posedge clk);
        #1;
        reset         = s.rst;
        id_rs1        = s.rs1;
        id_rs2        = s.rs2;
        id_uses_rs1   = s.u1;
        id_uses_rs2   = s.u2;
        id_ex_rd      = s.rd;
        id_ex_memread = s.memread;
        branch_taken  = s.br;
        mem_req       = s.req;
        mem_ready     = s.ready;

        // Counters are registered: this cycle shows the totals of earlier cycles.
        e.stall = m_stall;
        e.flush = m_flush;
        e.tmo   = m_tmo;

        lu = s.memread && (s.rd != 0) &&
             ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
        if (s.rst) begin
            e.outs  = 8'b0010_1000;
            m_wait  = 1'b0;
            m_cnt   = 0;
            m_stall = '0;
            m_flush = '0;
            m_tmo   = '0;
        end else begin
            last = m_wait && (m_cnt == T - 1);
            fz   = m_wait ? (!s.ready && !last) : (s.req && !s.ready);
            tmo  = m_wait && !s.ready && last;
            if (fz)        e.outs = 8'b0000_0110;
            else if (s.br) e.outs = 8'b1110_1000;
            else if (lu)   e.outs = 8'b0001_0000;
            else           e.outs = 8'b1100_0000;
            e.outs[0] = tmo;
            if (fz || lu)    m_stall = m_stall + 1;
            if (!fz && s.br) m_flush = m_flush + 1;
            if (tmo)         m_tmo = m_tmo + 1;
            if (!m_wait) begin
                if (s.req && !s.ready) begin
                    m_wait = 1'b1;
                    m_cnt  = 1;
                end
            end else if (s.ready || last) begin
                m_wait = 1'b0;
                m_cnt  = 0;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        exp_q.push_back(e);
    endtask

    // Monitor: one response per cycle, checked away from the rising edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t       e;
            logic [7:0] got;
            e   = exp_q.pop_front();
            got = {pc_write, if_id_write, if_id_flush, id_ex_bubble,
                   id_ex_flush, pipe_freeze, mem_wb_bubble, mem_timeout};
            checks++;
            if (got !== e.outs) begin
                errors++;
                $display("FAIL outs at %0t: got=%b required=%b", $time, got, e.outs);
            end
`ifdef HAZARD_PERF_EN
            checks++;
            if ({stall_cycles, flush_count, timeout_count} !== {e.stall, e.flush, e.tmo}) begin
                errors++;
                $display("FAIL perf at %0t: got=%0d/%0d/%0d required=%0d/%0d/%0d", $time,
                         stall_cycles, flush_count, timeout_count, e.stall, e.flush, e.tmo);
            end
`endif
        end
    end

    initial begin
        stim_t s;
        // Reset
        s = idle();
        s.rst = 1'b1;
        repeat (2) apply(s);
        // Load-use hit, then rd=x0, then rs1 not used
        s = idle(); s.memread = 1'b1; s.rd = 5'd5; s.rs1 = 5'd5; s.u1 = 1'b1;
        apply(s); apply(idle());
        s.rd = 5'd0; s.rs1 = 5'd0; apply(s);
        s.rd = 5'd5; s.rs1 = 5'd5; s.u1 = 1'b0; apply(s);
        s.u1 = 1'b0; s.u2 = 1'b1; s.rs2 = 5'd5; apply(s);
        // Branch together with load-use
        s = idle(); s.memread = 1'b1; s.rd = 5'd7; s.rs1 = 5'd7; s.u1 = 1'b1; s.br = 1'b1;
        apply(s); apply(idle());
        // Memory wait: 3 frozen cycles then ready
        s = idle(); s.req = 1'b1;
        repeat (3) apply(s);
        s.ready = 1'b1; apply(s); apply(idle());
        // Timeout with ready never arriving
        s = idle(); s.req = 1'b1;
        repeat (5) apply(s);
        apply(idle());
        // Branch held during a freeze, flushed in the release cycle
        s = idle(); s.req = 1'b1; s.br = 1'b1;
        repeat (2) apply(s);
        s.ready = 1'b1; apply(s); apply(idle());
        // Reset in the middle of a wait
        s = idle(); s.req = 1'b1;
        repeat (2) apply(s);
        s.rst = 1'b1; apply(s);
        s = idle(); repeat (T + 1) apply(s);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            s.rst     = ($urandom_range(0, 99) < 2);
            s.rs1     = 5'($urandom_range(0, 3));
            s.rs2     = 5'($urandom_range(0, 3));
            s.rd      = 5'($urandom_range(0, 3));
            s.u1      = ($urandom_range(0, 99) < 70);
            s.u2      = ($urandom_range(0, 99) < 50);
            s.memread = ($urandom_range(0, 99) < 50);
            s.br      = ($urandom_range(0, 99) < 20);
            s.req     = ($urandom_range(0, 99) < 40);
            s.ready   = ($urandom_range(0, 99) < 35);
            apply(s);
        end
        apply(idle());
        // Every pushed response must have been consumed by the monitor.
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Producer-side counterpart of the EX-stage forwarding logic. Forwarding resolves operand hazards by steering the bypass muxes; this block resolves the hazards that forwarding cannot.
- It generates the stall, bubble, flush and freeze controls for the 5-stage RISC-V pipeline, covering three hazard classes:
  - load-use hazards, detected in ID;
  - taken-branch flushes, resolved in EX;
  - multi-cycle data-memory waits in MEM, with a timeout.
- It sits beside the pipeline registers and drives their write enables and the ID/EX control-zeroing mux.

Parameters:
- MEM_TIMEOUT, 16: maximum number of cycles spent in MEM_WAIT before the access is abandoned. Legal range is 2..255.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- id_rs1  input  5  rs1 address of the instruction in ID.
- id_rs2  input  5  rs2 address of the instruction in ID.
- id_uses_rs1  input  1  the ID instruction actually reads rs1.
- id_uses_rs2  input  1  the ID instruction actually reads rs2.
- id_ex_rd  input  5  rd address of the instruction in EX.
- id_ex_memread  input  1  the EX instruction is a load.
- branch_taken  input  1  a branch/jump resolved taken in EX this cycle.
- mem_req  input  1  the MEM-stage instruction accesses data memory.
- mem_ready  input  1  data memory completes the access this cycle.
- pc_write  output  1  PC register write enable.
- if_id_write  output  1  IF/ID register write enable.
- if_id_flush  output  1  load a NOP into IF/ID.
- id_ex_bubble  output  1  zero the control signals entering ID/EX.
- id_ex_flush  output  1  load a NOP into ID/EX.
- pipe_freeze  output  1  hold the PC, IF/ID, ID/EX and EX/MEM registers.
- mem_wb_bubble  output  1  insert a NOP into MEM/WB.
- mem_timeout  output  1  one-cycle pulse when a memory wait is abandoned.

Behaviour:
- Reset: synchronous, active-high.
  - While reset=1: state=RUN, wait_cnt=0, perf counters=0.
  - Outputs while reset=1: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, id_ex_bubble=0, pipe_freeze=0, mem_wb_bubble=0, mem_timeout=0.
  - A reset during MEM_WAIT abandons the wait without a mem_timeout pulse.
- Load-use detect (combinational):
  - lu = id_ex_memread && id_ex_rd!=0 && ((id_uses_rs1 && id_rs1==id_ex_rd) || (id_uses_rs2 && id_rs2==id_ex_rd)).
  - x0 never causes a stall.
- FSM states: RUN, MEM_WAIT. wait_cnt is 8 bits.
- RUN:
  - If mem_req && !mem_ready: freeze the pipeline this cycle, go to MEM_WAIT, set wait_cnt=1.
  - Otherwise stay in RUN.
- MEM_WAIT:
  - If mem_ready: unfreeze this cycle and go to RUN.
  - Else if wait_cnt==MEM_TIMEOUT-1: unfreeze, pulse mem_timeout=1, go to RUN.
  - Else: stay frozen and increment wait_cnt.
  - mem_req is ignored in MEM_WAIT; it is assumed held.
- Freeze condition (fz), evaluated combinationally in the current cycle:
  - In RUN: mem_req && !mem_ready.
  - In MEM_WAIT: !mem_ready && wait_cnt!=MEM_TIMEOUT-1.
- Output priority, highest first:
  - 1. fz=1: pipe_freeze=1, mem_wb_bubble=1, pc_write=0, if_id_write=0, no flush, no bubble. A branch_taken or lu present this cycle is re-evaluated after release, because EX and ID are held.
  - 2. branch_taken=1: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1, id_ex_bubble=0. A concurrent lu is ignored because the ID instruction is squashed.
  - 3. lu=1: pc_write=0, if_id_write=0, id_ex_bubble=1. This is exactly one bubble cycle; the next cycle the load is in MEM and forwarding covers the hazard.
  - 4. Otherwise: pc_write=1, if_id_write=1, and all other outputs 0.
- mem_timeout is asserted only in the cycle that leaves MEM_WAIT on timeout.
- Latency: all outputs are combinational from the inputs and the current state; there is zero-cycle response.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, the block adds three outputs, each CNT_W bits wide:
  - stall_cycles: increments on every non-reset cycle with fz||lu.
  - flush_count: increments on every cycle where case 2 applies.
  - timeout_count: increments on every mem_timeout pulse.
- Counters wrap at 2^CNT_W and clear on reset.
- When not defined, these ports and counters do not exist; the base behaviour is identical.

Test Plan:
- Load-use: id_ex_memread=1, id_ex_rd=5, id_rs1=5, id_uses_rs1=1 -> for one cycle pc_write=0, if_id_write=0, id_ex_bubble=1. Repeat with id_ex_rd=0 -> no stall. Repeat with id_uses_rs1=0 -> no stall.
- Branch with load-use: branch_taken=1 and lu=1 in the same cycle -> if_id_flush=1, id_ex_flush=1, pc_write=1, id_ex_bubble=0.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> pipe_freeze=1 and mem_wb_bubble=1 for exactly 3 cycles; 0 in the ready cycle; state returns to RUN; no mem_timeout.
- Timeout: MEM_TIMEOUT=4, mem_req=1, mem_ready held 0 -> freeze for 3 cycles, then 1 cycle with pipe_freeze=0 and mem_timeout=1, then RUN.
- Freeze over branch: freeze active with branch_taken=1 -> no flush while frozen; flush asserted in the release cycle. Separately, reset asserted mid-MEM_WAIT -> state=RUN, wait_cnt=0, no mem_timeout.
- With HAZARD_PERF_EN defined: 1 load-use stall, 2 flushes and 1 timeout (MEM_TIMEOUT=4) -> stall_cycles=4, flush_count=2, timeout_count=1. After reset, all three read 0.
